// File: rtl/sort_result_checker_pkg.sv
// Shared definitions for the sort network result checker: lane geometry,
// checksum width, error flag indices and FSM encoding.
package sort_result_checker_pkg;

    localparam int ERR_W       = 4;
    localparam int ERR_ORDER   = 0;
    localparam int ERR_SUM     = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_PROTO   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FAIL = 2'd2
    } chk_state_t;

    function automatic int lanes(input int p_log);
        return 1 << p_log;
    endfunction

    // Sum of L keys needs log2(L) extra bits to never overflow.
    function automatic int sum_w(input int keyw, input int p_log);
        return keyw + p_log;
    endfunction

    // Low bit of lane's key within a packed vector; key occupies [lo +: KEYW].
    function automatic int key_lo(input int lane, input int datw);
        return lane * datw;
    endfunction

endpackage

// File: rtl/sort_result_checker_if.sv
// Stream snooped on the way into the sort network and consumed on the way out.
interface sort_result_checker_if #(
    parameter int P_LOG = 1,
    parameter int DATW  = 64
);
    logic [(DATW << P_LOG)-1:0] DIN;
    logic                       DINEN;
    logic [(DATW << P_LOG)-1:0] DOT;
    logic                       DOTEN;

    modport master (output DIN, DINEN, DOT, DOTEN);
    modport slave  (input  DIN, DINEN, DOT, DOTEN);
endinterface

// File: rtl/sort_result_checker_fifo.sv
// Expected-checksum FIFO; the caller only issues legal push/pop.
// Head is registered so the popped value is available without a read port.
module chk_fifo #(
    parameter int W   = 33,
    parameter int LOG = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam logic [LOG:0] DEPTH = (LOG+1)'(1 << LOG);

    logic [W-1:0]   mem [1 << LOG];
    logic [LOG-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [LOG:0]   cnt;

    assign full   = (cnt == DEPTH);
    assign empty  = (cnt == '0);
    assign rd_nxt = pop ? rd_ptr + LOG'(1) : rd_ptr;

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + LOG'(1);
            rd_ptr <= rd_nxt;
            case ({push, pop})
                2'b10:   cnt <= cnt + (LOG+1)'(1);
                2'b01:   cnt <= cnt - (LOG+1)'(1);
                default: cnt <= cnt;
            endcase
            // The entry being written becomes head when it lands on the new read slot.
            if (push && (rd_nxt == wr_ptr))
                head <= wdata;
            else
                head <= mem[rd_nxt];
        end
    end
endmodule

// File: rtl/sort_result_checker.sv
// Checks ordering and key-sum conservation of every vector leaving the sort
// network against the vectors that entered it, with a no-output watchdog.
module sort_result_checker
    import sort_result_checker_pkg::*;
#(
    parameter int P_LOG     = 1,
    parameter int DATW      = 64,
    parameter int KEYW      = 32,
    parameter int FIFO_LOG  = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    sort_result_checker_if.slave     strm,
    output logic [31:0]              VCNT,
    output logic [ERR_W-1:0]         ERR,
    output logic                     FAIL,
    output logic                     BUSY
);
    localparam int L    = lanes(P_LOG);
    localparam int SUMW = sum_w(KEYW, P_LOG);

    logic [SUMW-1:0]      din_sum, dot_sum, fifo_head;
    logic                 dot_ordered;
    logic                 fifo_full, fifo_empty;
    logic                 push_ok, pop_ok, proto_err;
    logic                 s1_vld, s1_ordered;
    logic [SUMW-1:0]      s1_dot_sum, s1_exp_sum;
    logic [TIMEOUT_W-1:0] wd_rem;
    logic                 wd_run, wd_expire;
    chk_state_t           state, state_nxt;

    logic unused_bits;
    assign unused_bits = ^{strm.DIN, strm.DOT};

    always_comb begin
        din_sum     = '0;
        dot_sum     = '0;
        dot_ordered = 1'b1;
        for (int i = 0; i < L; i++) begin
            din_sum = din_sum + SUMW'(strm.DIN[key_lo(i, DATW) +: KEYW]);
            dot_sum = dot_sum + SUMW'(strm.DOT[key_lo(i, DATW) +: KEYW]);
        end
        for (int i = 0; i < L-1; i++) begin
            if (strm.DOT[key_lo(i, DATW) +: KEYW] > strm.DOT[key_lo(i+1, DATW) +: KEYW])
                dot_ordered = 1'b0;
        end
    end

    // A pop into an empty FIFO is an underflow even if a push lands this cycle.
    assign pop_ok    = strm.DOTEN && !fifo_empty;
    assign push_ok   = strm.DINEN && (!fifo_full || pop_ok);
    assign proto_err = (strm.DINEN && fifo_full && !pop_ok) || (strm.DOTEN && fifo_empty);

    chk_fifo #(.W(SUMW), .LOG(FIFO_LOG)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push_ok),
        .pop   (pop_ok),
        .wdata (din_sum),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign BUSY = !fifo_empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_vld     <= 1'b0;
            s1_ordered <= 1'b1;
            s1_dot_sum <= '0;
            s1_exp_sum <= '0;
            VCNT       <= '0;
            ERR        <= '0;
            FAIL       <= 1'b0;
        end else begin
            s1_vld     <= pop_ok;
            s1_ordered <= dot_ordered;
            s1_dot_sum <= dot_sum;
            s1_exp_sum <= fifo_head;
            if (s1_vld) begin
                VCNT <= VCNT + 32'd1;
                if (!s1_ordered)
                    ERR[ERR_ORDER] <= 1'b1;
                if (s1_dot_sum != s1_exp_sum)
                    ERR[ERR_SUM] <= 1'b1;
            end
            if (proto_err)
                ERR[ERR_PROTO] <= 1'b1;
            if (wd_expire)
                ERR[ERR_TIMEOUT] <= 1'b1;
            FAIL <= |ERR;
        end
    end

    // Watchdog counts down from all-ones; expiry fires on the step into zero and then holds.
    assign wd_expire = wd_run && !strm.DOTEN && (wd_rem == TIMEOUT_W'(1));

    always_ff @(posedge CLK) begin
        if (RST || !wd_run || strm.DOTEN)
            wd_rem <= '1;
        else if (wd_rem != '0)
            wd_rem <= wd_rem - TIMEOUT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (!fifo_empty) state_nxt = ST_WAIT;
            ST_WAIT: if (fifo_empty)  state_nxt = ST_IDLE;
            default: state_nxt = ST_FAIL;
        endcase
        if (|ERR)
            state_nxt = ST_FAIL;
    end

    always_comb begin
        wd_run = 1'b0;
        case (state)
            ST_WAIT: wd_run = 1'b1;
            ST_FAIL: wd_run = !fifo_empty;
            default: wd_run = 1'b0;
        endcase
    end
endmodule

// File: doc/sort_result_checker.md
# sort_result_checker

Self-checking sink for the odd-even mergesort network. It snoops the vector stream driven into the network (DIN/DINEN) and consumes the stream leaving it (DOT/DOTEN). For every output vector it checks:
- ascending key order across lanes;
- that the key sum matches the next outstanding input vector, in FIFO order.

It reports sticky error flags, a checked-vector count and a pass/fail summary that board LEDs or a frequency-evaluation top can expose.

## Interface
Parameters:
- P_LOG, 1: log2 of lanes per vector (L = 1<<P_LOG)
- DATW, 64: record width per lane
- KEYW, 32: key width; key = record[KEYW-1:0]
- FIFO_LOG, 4: log2 of the expected-checksum FIFO depth
- TIMEOUT_W, 16: width of the no-output watchdog counter

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high; clock CLK
- DIN  in  DATW<<P_LOG  vector presented to the network; lane i = DIN[DATW*(i+1)-1:DATW*i]
- DINEN  in  1  DIN valid this cycle
- DOT  in  DATW<<P_LOG  sorted vector from the network, same lane layout
- DOTEN  in  1  DOT valid this cycle
- VCNT  out  32  number of output vectors checked; wraps modulo 2^32
- ERR  out  4  sticky flags: [0] order, [1] checksum, [2] timeout, [3] protocol (FIFO overflow or underflow)
- FAIL  out  1  OR of ERR, registered
- BUSY  out  1  at least one input vector is outstanding (FIFO not empty)

## Operation
- Checksum: unsigned sum of the L keys of a vector, computed at KEYW+P_LOG bits so it never overflows.
- Input side: DINEN=1 pushes the checksum of DIN.
  - FIFO full and no same-cycle pop: the push is dropped and ERR[3] is set.
  - Full with a same-cycle pop: the push is accepted.
- Output side: DOTEN=1 pops the FIFO head.
  - FIFO empty and no same-cycle push: ERR[3] is set and no compare is done.
  - Empty with a same-cycle push: this is also an underflow, because the network latency is at least 1 cycle. ERR[3] is set, the push is kept, and the pop does not happen.
- Order check: key[i] <= key[i+1] for all i < L-1, unsigned. Equal keys pass. A violation sets ERR[0].
- Checksum check: a mismatch between the DOT sum and the popped expected sum sets ERR[1].
- VCNT increments once per DOTEN that has a valid pop, regardless of the check outcome.
- FSM, 3 states:
  - IDLE: FIFO empty. Go to WAIT when the FIFO becomes non-empty.
  - WAIT: watchdog counts every cycle without DOTEN and clears on DOTEN. On reaching 2^TIMEOUT_W-1 it saturates and sets ERR[2]. Go back to IDLE when the FIFO becomes empty.
  - FAIL: entered from any state when any ERR bit is set. Terminal until RST. Checks, FIFO, VCNT and the watchdog keep running so further ERR bits can accumulate.
- RST at any time clears the FIFO, counters, ERR, the pipeline and the FSM (to IDLE) in the same cycle, whatever transfers are in flight.

## Timing
- Reset values: VCNT=0, ERR=0, FAIL=0, BUSY=0.
- Stage 1, the edge that samples DOTEN: register the order flag, the DOT sum, the popped expected sum and a valid bit.
- Stage 2, the next edge: update ERR[1:0] and VCNT.
- FAIL updates one edge after the ERR change.
- ERR[3] is set at the edge that samples the offending DINEN/DOTEN.
- BUSY reflects FIFO occupancy after each edge.
- One input vector and one output vector per cycle are sustained indefinitely, with no stalls and no backpressure.

## Structure
- Shared package holds:
  - lane count L and the key-slice helper;
  - checksum width KEYW+P_LOG;
  - ERR bit indices;
  - FSM state encoding (IDLE/WAIT/FAIL).
- One sub-module, chk_fifo: synchronous FIFO, width KEYW+P_LOG, depth 1<<FIFO_LOG. Simultaneous push and pop are legal. Outputs full/empty and a registered head.
- The rest is top-level: adder trees, comparators, watchdog, FSM.

## Test plan
All cases use P_LOG=1, KEYW=32.
- Normal vector: DIN keys {lane1=1, lane0=2}, then 3 cycles later DOT keys {lane1=2, lane0=1} -> VCNT=1, ERR=0, FAIL=0, BUSY back to 0.
- Order error: input {1,2}, output {lane1=1, lane0=2} -> ERR=4'b0001, FAIL=1 one cycle later, VCNT=1.
- Checksum error: input sum 3, output keys {3,1} (sum 4) -> ERR=4'b0010.
- Timeout: one DINEN and no DOTEN for 65535 cycles (TIMEOUT_W=16) -> ERR[2]=1, BUSY=1.
- Protocol errors:
  - DOTEN with the FIFO empty -> ERR[3]=1, VCNT unchanged.
  - 17 DINEN pulses with no DOTEN (FIFO_LOG=4) -> ERR[3]=1 on the 17th.
- Back-to-back and reset:
  - 100 back-to-back correct vectors at latency 5 -> VCNT=100, ERR=0.
  - RST asserted mid-stream -> all outputs 0 next cycle and checking restarts cleanly.
